// File: rtl/hdmi_ctrl_pkg.sv
// Shared definitions for the HDMI output path: FSM state encoding, 640x480@60
// default timing, the line/frame total derivation and the colour-bar palette.
package hdmi_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RESYNC = 2'd1,
    ST_ARMED  = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
  localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
  localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] BAR_RED     = 24'hFF0000;
  localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
  localparam logic [23:0] BAR_BLACK   = 24'h000000;

  function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Free-running pixel/line counters with combinational region flags.
// With TEST_PATTERN_EN the horizontal position is exported for the colour bars.
module video_timing_gen import hdmi_ctrl_pkg::*; #(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int HW      = $clog2(H_TOTAL),
  localparam int VW      = $clog2(V_TOTAL)
) (
  input  logic          clk_pixel,
  input  logic          rst,
`ifdef TEST_PATTERN_EN
  output logic [HW-1:0] h_pos,
`endif
  output logic          active,
  output logic          hs,
  output logic          vs,
  output logic          first,
  output logic          last
);

  logic [HW-1:0] h_cnt_reg;
  logic [VW-1:0] v_cnt_reg;

  always_ff @(posedge clk_pixel or negedge rst) begin
    if (!rst) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == HW'(H_TOTAL - 1)) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == VW'(V_TOTAL - 1)) ? '0 : v_cnt_reg + 1'b1;
    end else begin
      h_cnt_reg <= h_cnt_reg + 1'b1;
    end
  end

  assign active = (h_cnt_reg < HW'(H_ACTIVE)) && (v_cnt_reg < VW'(V_ACTIVE));
  assign hs     = (h_cnt_reg >= HW'(H_ACTIVE + H_FP)) && (h_cnt_reg < HW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs     = (v_cnt_reg >= VW'(V_ACTIVE + V_FP)) && (v_cnt_reg < VW'(V_ACTIVE + V_FP + V_SYNC));
  assign first  = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign last   = (h_cnt_reg == HW'(H_TOTAL - 1)) && (v_cnt_reg == VW'(V_TOTAL - 1));

`ifdef TEST_PATTERN_EN
  assign h_pos = h_cnt_reg;
`endif

endmodule

// File: rtl/hdmi_stream_ctrl.sv
// HDMI output sequencer: video timing, stream lock/relock FSM and registered pixel outputs.
// Optional TEST_PATTERN_EN adds pattern_sel, which replaces the stream with 8 colour bars.
module hdmi_stream_ctrl import hdmi_ctrl_pkg::*; #(
  parameter int          H_ACTIVE = DEF_H_ACTIVE,
  parameter int          H_FP     = DEF_H_FP,
  parameter int          H_SYNC   = DEF_H_SYNC,
  parameter int          H_BP     = DEF_H_BP,
  parameter int          V_ACTIVE = DEF_V_ACTIVE,
  parameter int          V_FP     = DEF_V_FP,
  parameter int          V_SYNC   = DEF_V_SYNC,
  parameter int          V_BP     = DEF_V_BP,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter logic [23:0] FILL_RGB = 24'h000000
) (
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] s_data,
  input  logic        s_sof,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  RED,
  output logic [7:0]  GREEN,
  output logic [7:0]  BLUE,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        video_de,
  output logic        frame_start,
  input  logic        clr_err,
  output logic        underflow_err,
  output logic        sof_err
`ifdef TEST_PATTERN_EN
  ,
  input  logic        pattern_sel
`endif
);

  logic active, hs, vs, first, last;
  logic pattern_on;
  logic [23:0] bar_color;
  state_t state_reg;
  logic [23:0] rgb_reg;
  logic hsync_reg, vsync_reg, de_reg, fs_reg, underflow_reg, sof_err_reg;

`ifdef TEST_PATTERN_EN
  localparam int HW    = $clog2(timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int BAR_W = H_ACTIVE / 8;
  logic [HW-1:0] h_pos;
  assign pattern_on = pattern_sel;
  assign bar_color  = bar_rgb(3'(h_pos / HW'(BAR_W)));
`else
  assign pattern_on = 1'b0;
  assign bar_color  = 24'h000000;
`endif

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_pixel(clk_pixel),
    .rst(rst),
`ifdef TEST_PATTERN_EN
    .h_pos(h_pos),
`endif
    .active(active),
    .hs(hs),
    .vs(vs),
    .first(first),
    .last(last)
  );

  // Ready never looks at s_valid; in RUN it refuses any beat whose sof flag disagrees with the position.
  always_comb begin
    s_ready = 1'b0;
    if (!pattern_on) begin
      case (state_reg)
        ST_RESYNC: s_ready = !s_sof;
        ST_RUN:    s_ready = active && !(s_sof && !first) && !(first && !s_sof);
        default:   s_ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      rgb_reg       <= '0;
      hsync_reg     <= ~HS_POL;
      vsync_reg     <= ~VS_POL;
      de_reg        <= 1'b0;
      fs_reg        <= 1'b0;
      underflow_reg <= 1'b0;
      sof_err_reg   <= 1'b0;
    end else begin
      hsync_reg <= hs ? HS_POL : ~HS_POL;
      vsync_reg <= vs ? VS_POL : ~VS_POL;
      de_reg    <= active;
      fs_reg    <= first;
      rgb_reg   <= active ? FILL_RGB : 24'h000000;
      // Clear first so a same-cycle error set below takes precedence.
      if (clr_err) begin
        underflow_reg <= 1'b0;
        sof_err_reg   <= 1'b0;
      end
      if (pattern_on) begin
        state_reg <= ST_IDLE;
        if (active) rgb_reg <= bar_color;
      end else begin
        case (state_reg)
          ST_IDLE:   if (enable) state_reg <= ST_RESYNC;
          ST_RESYNC: if (s_valid && s_sof) state_reg <= ST_ARMED;
          ST_ARMED:  if (last) state_reg <= ST_RUN;
          ST_RUN: begin
            if (active) begin
              if (!s_valid) begin
                underflow_reg <= 1'b1;
                state_reg     <= ST_RESYNC;
              end else if (s_sof != first) begin
                sof_err_reg <= 1'b1;
                state_reg   <= ST_RESYNC;
              end else begin
                rgb_reg <= s_data;
              end
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
        if (!enable) state_reg <= ST_IDLE;
      end
    end
  end

  assign RED           = rgb_reg[23:16];
  assign GREEN         = rgb_reg[15:8];
  assign BLUE          = rgb_reg[7:0];
  assign HSYNC         = hsync_reg;
  assign VSYNC         = vsync_reg;
  assign video_de      = de_reg;
  assign frame_start   = fs_reg;
  assign underflow_err = underflow_reg;
  assign sof_err       = sof_err_reg;

endmodule

// File: tb/tb_hdmi_stream_ctrl.sv
// Self-checking bench for hdmi_stream_ctrl on a reduced raster (24x12 total, 16x6 active).
// Expected pixels per frame are derived from the stream scenario, not from the FSM.
module tb_hdmi_stream_ctrl;

  localparam int HA = 16, HFP = 2, HSW = 3, HBP = 3;
  localparam int VA = 6,  VFP = 1, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FRAME = HT * VT;
  localparam int NPIX = HA * VA;
  localparam logic [23:0] FILL = 24'h5A5A5A;

  logic clk_pixel = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic [23:0] s_data = '0;
  logic s_sof = 1'b0, s_valid = 1'b0, clr_err = 1'b0;
  logic s_ready;
  logic [7:0] RED, GREEN, BLUE;
  logic HSYNC, VSYNC, video_de, frame_start, underflow_err, sof_err;
`ifdef TEST_PATTERN_EN
  logic pattern_sel = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int frame_no = 0;
  logic [24:0] q[$];
  logic [23:0] exp_pix [NPIX];
  logic [23:0] fa [NPIX];
  logic [23:0] fb [NPIX];

  int bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, bad_at;
  logic [1:0] err_clr, err_drop;
  logic [23:0] bad_got, bad_exp;

  always #5 clk_pixel = ~clk_pixel;

  hdmi_stream_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .FILL_RGB(FILL)
  ) dut (
    .clk_pixel(clk_pixel), .rst(rst), .enable(enable),
    .s_data(s_data), .s_sof(s_sof), .s_valid(s_valid), .s_ready(s_ready),
    .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .video_de(video_de), .frame_start(frame_start),
    .clr_err(clr_err), .underflow_err(underflow_err), .sof_err(sof_err)
`ifdef TEST_PATTERN_EN
    , .pattern_sel(pattern_sel)
`endif
  );

  // Push a stream frame of len beats (sof on the first) with random pixels.
  task automatic gen_frame(input int len, output logic [23:0] f [NPIX]);
    for (int i = 0; i < NPIX; i++) f[i] = 24'h0;
    for (int i = 0; i < len; i++) begin
      f[i] = 24'($urandom);
      q.push_back({(i == 0), f[i]});
    end
  endtask

  // Play one full raster frame starting at (0,0) and tally deviations from exp_pix / spec timing.
  task automatic run_frame(input int drop_pos, input int clr_pos,
                           output int n_rgb, output int n_sync, output int n_beats,
                           output int n_hs, output int n_vs, output int n_de,
                           output logic [1:0] e_clr, output logic [1:0] e_drop,
                           output int first_bad, output logic [23:0] got_bad, output logic [23:0] exp_bad);
    n_rgb = 0; n_sync = 0; n_beats = 0; n_hs = 0; n_vs = 0; n_de = 0;
    e_clr = 2'bxx; e_drop = 2'bxx; first_bad = -1; got_bad = '0; exp_bad = '0;
    for (int p = 0; p < FRAME; p++) begin
      int x;
      int y;
      logic act, acc;
      logic [23:0] e;
      x = p % HT;
      y = p / HT;
      if (q.size() > 0 && p != drop_pos) begin
        s_valid = 1'b1;
        s_sof   = q[0][24];
        s_data  = q[0][23:0];
      end else begin
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = 24'($urandom);
      end
      clr_err = (p == clr_pos);
      @(negedge clk_pixel);
      acc = s_valid && s_ready;
      @(posedge clk_pixel);
      #1;
      if (acc) begin
        void'(q.pop_front());
        n_beats++;
      end
      act = (x < HA) && (y < VA);
      e = act ? exp_pix[y * HA + x] : 24'h0;
      if ({RED, GREEN, BLUE} !== e) begin
        if (first_bad < 0) begin
          first_bad = p;
          got_bad = {RED, GREEN, BLUE};
          exp_bad = e;
        end
        n_rgb++;
      end
      if (HSYNC !== ((x >= HA + HFP && x < HA + HFP + HSW) ? 1'b0 : 1'b1)) n_sync++;
      if (VSYNC !== ((y >= VA + VFP && y < VA + VFP + VSW) ? 1'b0 : 1'b1)) n_sync++;
      if (video_de !== act) n_sync++;
      if (frame_start !== (p == 0)) n_sync++;
      if (HSYNC === 1'b0) n_hs++;
      if (VSYNC === 1'b0) n_vs++;
      if (video_de === 1'b1) n_de++;
      if (p == clr_pos) e_clr = {underflow_err, sof_err};
      if (p == drop_pos) e_drop = {underflow_err, sof_err};
    end
    clr_err = 1'b0;
    $display("frame %0d: beats=%0d bad_rgb=%0d bad_sync=%0d uf=%b sof=%b", frame_no, n_beats, n_rgb, n_sync, underflow_err, sof_err);
    frame_no++;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_pixel);
    #2;
    checks++;
    if ({HSYNC, VSYNC, video_de, frame_start} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_sync: got %b expected 1100", {HSYNC, VSYNC, video_de, frame_start});
    end
    checks++;
    if ({RED, GREEN, BLUE} !== 24'h0) begin
      failures++;
      $display("FAIL reset_rgb: got %06h expected 000000", {RED, GREEN, BLUE});
    end
    checks++;
    if ({underflow_err, sof_err, s_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags: got %b expected 000", {underflow_err, sof_err, s_ready});
    end
    @(posedge clk_pixel);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_timing();
    enable = 1'b0;
    for (int i = 0; i < NPIX; i++) exp_pix[i] = FILL;
    run_frame(-1, -1, bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, err_clr, err_drop, bad_at, bad_got, bad_exp);
    checks++;
    if (bad_rgb !== 0) begin failures++; $display("FAIL idle_rgb: %0d bad, first at %0d got %06h expected %06h", bad_rgb, bad_at, bad_got, bad_exp); end
    checks++;
    if (bad_sync !== 0) begin failures++; $display("FAIL idle_sync: got %0d misplaced sync/de/fs cycles expected 0", bad_sync); end
    checks++;
    if (hs_low !== HSW * VT) begin failures++; $display("FAIL hsync_low_count: got %0d expected %0d", hs_low, HSW * VT); end
    checks++;
    if (vs_low !== VSW * HT) begin failures++; $display("FAIL vsync_low_count: got %0d expected %0d", vs_low, VSW * HT); end
    checks++;
    if (de_cnt !== NPIX) begin failures++; $display("FAIL de_count: got %0d expected %0d", de_cnt, NPIX); end
  endtask

  task automatic test_stream();
    gen_frame(NPIX, fa);
    enable = 1'b1;
    for (int i = 0; i < NPIX; i++) exp_pix[i] = FILL;
    run_frame(-1, -1, bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, err_clr, err_drop, bad_at, bad_got, bad_exp);
    checks++;
    if (bad_rgb !== 0 || beats !== 0) begin failures++; $display("FAIL lock_frame: bad_rgb=%0d beats=%0d expected 0/0", bad_rgb, beats); end
    for (int f = 0; f < 2; f++) begin
      exp_pix = fa;
      run_frame(-1, -1, bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, err_clr, err_drop, bad_at, bad_got, bad_exp);
      checks++;
      if (bad_rgb !== 0) begin failures++; $display("FAIL stream_rgb: %0d bad, first at %0d got %06h expected %06h", bad_rgb, bad_at, bad_got, bad_exp); end
      checks++;
      if (beats !== NPIX || bad_sync !== 0) begin failures++; $display("FAIL stream_beats: beats=%0d sync_bad=%0d expected %0d/0", beats, bad_sync, NPIX); end
      checks++;
      if ({underflow_err, sof_err} !== 2'b00) begin failures++; $display("FAIL stream_errs: got %b expected 00", {underflow_err, sof_err}); end
      if (f == 0) gen_frame(NPIX, fa);
    end
  endtask

  // Drop s_valid for one cycle at a random active pixel; optionally clear errors on that same cycle.
  task automatic test_underflow(input logic with_clr);
    int x, y, i, dpos;
    gen_frame(NPIX, fa);
    gen_frame(NPIX, fb);
    x = $urandom_range(HA - 1, 0);
    y = $urandom_range(VA - 1, 0);
    if (x == 0 && y == 0) x = 1;
    i = y * HA + x;
    dpos = y * HT + x;
    for (int j = 0; j < NPIX; j++) exp_pix[j] = (j < i) ? fa[j] : FILL;
    run_frame(dpos, with_clr ? dpos : -1, bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, err_clr, err_drop, bad_at, bad_got, bad_exp);
    checks++;
    if (bad_rgb !== 0) begin failures++; $display("FAIL underflow_rgb (drop %0d,%0d): %0d bad, first at %0d got %06h expected %06h", x, y, bad_rgb, bad_at, bad_got, bad_exp); end
    checks++;
    if (err_drop !== 2'b10) begin failures++; $display("FAIL underflow_flag (clr=%b): got %b expected 10", with_clr, err_drop); end
    checks++;
    if (beats !== NPIX) begin failures++; $display("FAIL underflow_flush: got %0d beats expected %0d", beats, NPIX); end
    exp_pix = fb;
    run_frame(-1, with_clr ? HA : -1, bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, err_clr, err_drop, bad_at, bad_got, bad_exp);
    checks++;
    if (bad_rgb !== 0 || beats !== NPIX) begin failures++; $display("FAIL relock_rgb: bad=%0d beats=%0d expected 0/%0d", bad_rgb, beats, NPIX); end
    checks++;
    if (with_clr && err_clr !== 2'b00) begin failures++; $display("FAIL clr_alone: got %b expected 00", err_clr); end
    else if (!with_clr && underflow_err !== 1'b1) begin failures++; $display("FAIL underflow_sticky: got %b expected 1", underflow_err); end
  endtask

  task automatic test_clear();
    gen_frame(NPIX, fa);
    exp_pix = fa;
    run_frame(-1, HA + 1, bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, err_clr, err_drop, bad_at, bad_got, bad_exp);
    checks++;
    if (err_clr !== 2'b00) begin failures++; $display("FAIL clr_err: got %b expected 00", err_clr); end
    checks++;
    if (bad_rgb !== 0 || beats !== NPIX) begin failures++; $display("FAIL clear_frame: bad=%0d beats=%0d expected 0/%0d", bad_rgb, beats, NPIX); end
  endtask

  task automatic test_sof_err();
    int k;
    k = $urandom_range(NPIX - 1, 1);
    gen_frame(k, fa);
    gen_frame(NPIX, fb);
    for (int j = 0; j < NPIX; j++) exp_pix[j] = (j < k) ? fa[j] : FILL;
    run_frame(-1, -1, bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, err_clr, err_drop, bad_at, bad_got, bad_exp);
    checks++;
    if (bad_rgb !== 0) begin failures++; $display("FAIL sof_err_rgb (k=%0d): %0d bad, first at %0d got %06h expected %06h", k, bad_rgb, bad_at, bad_got, bad_exp); end
    checks++;
    if (beats !== k) begin failures++; $display("FAIL sof_err_beats: got %0d expected %0d", beats, k); end
    checks++;
    if ({underflow_err, sof_err} !== 2'b01) begin failures++; $display("FAIL sof_err_flag: got %b expected 01", {underflow_err, sof_err}); end
    exp_pix = fb;
    run_frame(-1, -1, bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, err_clr, err_drop, bad_at, bad_got, bad_exp);
    checks++;
    if (bad_rgb !== 0 || beats !== NPIX) begin failures++; $display("FAIL sof_relock: bad=%0d first at %0d got %06h expected %06h beats=%0d", bad_rgb, bad_at, bad_got, bad_exp, beats); end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    logic [23:0] bars [8];
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00, 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    pattern_sel = 1'b1;
    gen_frame(NPIX, fa);
    for (int j = 0; j < NPIX; j++) exp_pix[j] = bars[(j % HA) / (HA / 8)];
    run_frame(-1, -1, bad_rgb, bad_sync, beats, hs_low, vs_low, de_cnt, err_clr, err_drop, bad_at, bad_got, bad_exp);
    checks++;
    if (bad_rgb !== 0) begin failures++; $display("FAIL pattern_rgb: %0d bad, first at %0d got %06h expected %06h", bad_rgb, bad_at, bad_got, bad_exp); end
    checks++;
    if (beats !== 0) begin failures++; $display("FAIL pattern_ready: got %0d beats expected 0", beats); end
    pattern_sel = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_stream();
    test_underflow(1'b0);
    test_clear();
    test_sof_err();
    test_underflow(1'b1);
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
